// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

    // Arbiter FSM: waiting for a requester, or serving an atomic burst.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Source-ID tag width; a single bit is kept even for degenerate counts.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i,
// wrapping modulo NUM_REQ.
module rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_req_o
);

    // Scan NUM_REQ positions starting at the pointer; first hit wins.
    always_comb begin
        logic              found;
        int unsigned       idx;
        logic [ID_W-1:0]   idx_w;
        winner_o  = '0;
        any_req_o = |req_i;
        found     = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx   = (32'(rr_ptr_i) + i) % 32'(NUM_REQ);
            idx_w = ID_W'(idx);
            if (!found && req_i[idx_w]) begin
                winner_o = idx_w;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO (clk_a domain).
// Grants one requester an atomic burst of up to MAX_BURST beats and tags
// every written word with the source ID.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 64,
    parameter int  MAX_BURST  = 4,
    localparam int ID_W       = id_width(NUM_REQ)
) (
    input  logic                          clk_a,
    input  logic                          rst_a,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ID_W+DATA_WIDTH-1:0]    fifo_din,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BCNT_W-1:0] beat_q, beat_d;

    logic [ID_W-1:0]       pick_winner;
    logic                  pick_any;
    logic                  xfer;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] owner_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i     (req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .winner_o  (pick_winner),
        .any_req_o (pick_any)
    );

    // Unflatten payloads and decode the one-hot ready from the current owner.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign data_arr[g]  = req_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign req_ready[g] = xfer && (grant_q == ID_W'(g));
    end

    // Transfer qualification and owner data mux.
    always_comb begin
        xfer       = (state_q == BURST) && req_valid[grant_q] && !fifo_full;
        last_beat  = req_last[grant_q] || (beat_q == BCNT_W'(MAX_BURST - 1));
        owner_data = data_arr[grant_q];
    end

    assign fifo_wr_en = xfer;
    assign fifo_din   = {grant_q, owner_data};
    assign grant_id   = grant_q;
    assign busy       = (state_q == BURST);

    // Next-state: grant in IDLE, count beats in BURST, release on last beat.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_winner;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    if (last_beat) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                    end else begin
                        beat_d = beat_q + BCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant, pointer and beat counter registers.
    always_ff @(posedge clk_a or negedge rst_a) begin
        if (!rst_a) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: behavioural model plus scoreboard,
// directed scenarios and randomized traffic.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int MB = 4;
    localparam int IW = 2;

    logic              clk_a;
    logic              rst_a;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [IW+DW-1:0]  fifo_din;
    logic              fifo_wr_en;
    logic              fifo_full;
    logic [IW-1:0]     grant_id;
    logic              busy;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk_a      (clk_a),
        .rst_a      (rst_a),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clk_a = 1'b0;
    always #5 clk_a = ~clk_a;

    // Requester generators
    int unsigned seq [N];
    int unsigned pos [N];
    int unsigned plen [N];
    int unsigned budget [N];
    bit          want [N];
    bit          full_w;
    bit          rand_mode;
    logic [N-1:0] prev_ready;

    // Scoreboard / trace
    int unsigned sb_cnt [N];
    int unsigned cyc;
    int unsigned wr_cyc [$];
    int unsigned wr_tag [$];

    int n_chk;
    int n_fail;

    // Reference model
    bit          m_busy;
    int unsigned m_owner;
    int unsigned m_ptr;
    int unsigned m_beats;

    function automatic logic [DW-1:0] word(input int unsigned src, input int unsigned s);
        return {8'(src), 56'(s)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance handshakes seen last cycle, then drive this cycle's inputs.
    task automatic step();
        @(negedge clk_a);
        for (int i = 0; i < N; i++) begin
            if (prev_ready[i]) begin
                seq[i]++;
                pos[i]++;
                if (budget[i] > 0) budget[i]--;
                if (pos[i] >= plen[i]) begin
                    pos[i] = 0;
                    if (rand_mode) plen[i] = $urandom_range(1, 8);
                end
            end
        end
        prev_ready = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = want[i] && (budget[i] > 0);
            req_last[i]           = (pos[i] == plen[i] - 1);
            req_data[i*DW +: DW]  = word(i, seq[i]);
        end
        fifo_full = full_w;
    endtask

    task automatic do_reset();
        @(posedge clk_a);
        #1 rst_a = 1'b0;
        step();
        @(posedge clk_a);
        #1 rst_a = 1'b1;
    endtask

    task automatic clear_trace();
        wr_cyc.delete();
        wr_tag.delete();
    endtask

    // Compare process: checks every cycle against the model, then steps it.
    initial begin
        bit           exp_xfer;
        logic [N-1:0] exp_ready;
        int unsigned  tag;
        int unsigned  idx;
        bit           found;
        cyc = 0;
        forever begin
            @(negedge clk_a);
            #2;
            if (!rst_a) begin
                chk("rst_busy", busy, 0);
                chk("rst_wr_en", fifo_wr_en, 0);
                chk("rst_ready", req_ready, 0);
                chk("rst_grant", grant_id, 0);
                m_busy  = 0;
                m_ptr   = 0;
                m_owner = 0;
                m_beats = 0;
            end else begin
                exp_xfer  = m_busy && req_valid[m_owner] && !fifo_full;
                exp_ready = '0;
                if (exp_xfer) exp_ready[m_owner] = 1'b1;
                chk("busy", busy, m_busy);
                chk("grant_id", grant_id, m_owner);
                chk("fifo_wr_en", fifo_wr_en, exp_xfer);
                chk("req_ready", req_ready, exp_ready);
                if (exp_xfer)
                    chk("fifo_din", fifo_din, {IW'(m_owner), req_data[m_owner*DW +: DW]});
                if (fifo_wr_en) begin
                    tag = int'(fifo_din[IW+DW-1:DW]);
                    chk("sb_word", fifo_din[DW-1:0], word(tag, sb_cnt[tag]));
                    sb_cnt[tag]++;
                    wr_cyc.push_back(cyc);
                    wr_tag.push_back(tag);
                end
                if (!m_busy) begin
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        idx = (m_ptr + k) % N;
                        if (!found && req_valid[idx]) begin
                            found   = 1;
                            m_owner = idx;
                            m_busy  = 1;
                            m_beats = 0;
                        end
                    end
                end else if (exp_xfer) begin
                    if (req_last[m_owner] || m_beats == MB - 1) begin
                        m_busy = 0;
                        m_ptr  = (m_owner + 1) % N;
                    end else begin
                        m_beats++;
                    end
                end
            end
            prev_ready = req_ready;
            cyc++;
        end
    end

    initial begin
        int unsigned c0;
        int unsigned w0;
        int unsigned cnt;
        int unsigned max2;
        int unsigned min0;
        int unsigned n0;
        bit          ok;
        int unsigned tot_acc;
        int unsigned tot_wr;

        n_chk = 0;
        n_fail = 0;
        rst_a = 1'b0;
        full_w = 0;
        rand_mode = 0;
        prev_ready = '0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0; pos[i] = 0; plen[i] = 1; budget[i] = 0; want[i] = 0; sb_cnt[i] = 0;
        end
        m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;

        repeat (3) step();
        #3;
        chk("reset_busy_lit", busy, 0);
        chk("reset_wr_en_lit", fifo_wr_en, 0);
        @(posedge clk_a);
        #1 rst_a = 1'b1;

        // Single requester, 3-beat packet
        clear_trace();
        plen[1] = 3; budget[1] = 3; want[1] = 1;
        step();
        c0 = cyc;
        repeat (4) step();
        #3;
        chk("t1_busy_after", busy, 0);
        repeat (2) step();
        want[1] = 0;
        chk("t1_nwrites", wr_cyc.size(), 3);
        for (int j = 0; j < 3 && j < wr_cyc.size(); j++) begin
            chk("t1_cycle", wr_cyc[j], c0 + 1 + j);
            chk("t1_tag", wr_tag[j], 1);
        end

        // All four requesting with 8-beat packets
        do_reset();
        clear_trace();
        for (int i = 0; i < N; i++) begin
            plen[i] = 8; budget[i] = 8; want[i] = 1;
        end
        repeat (45) step();
        for (int i = 0; i < N; i++) want[i] = 0;
        chk("t2_nwrites", wr_cyc.size(), 32);
        ok = (wr_cyc.size() == 32);
        for (int j = 0; j < 32 && j < wr_cyc.size(); j++) begin
            if (wr_tag[j] != (j / 4) % 4) ok = 0;
            if (j > 0 && (wr_cyc[j] - wr_cyc[j-1]) != ((j % 4 == 0) ? 2 : 1)) ok = 0;
        end
        chk("t2_grant_pattern", ok, 1);

        // fifo_full for 5 cycles mid-burst
        clear_trace();
        plen[0] = 8; budget[0] = 8; want[0] = 1;
        repeat (3) step();
        full_w = 1;
        step();
        w0 = cyc;
        repeat (4) step();
        full_w = 0;
        repeat (12) step();
        want[0] = 0;
        cnt = 0;
        foreach (wr_cyc[j]) if (wr_cyc[j] >= w0 && wr_cyc[j] <= w0 + 4) cnt++;
        chk("t3_writes_while_full", cnt, 0);
        chk("t3_nwrites", wr_cyc.size(), 8);

        // Owner 2 drops valid mid-burst while 0 waits
        clear_trace();
        plen[2] = 4; budget[2] = 4; want[2] = 1;
        repeat (2) step();
        want[2] = 0;
        plen[0] = 2; budget[0] = 2; want[0] = 1;
        repeat (3) begin
            step();
            #3;
            chk("t4_grant_held", grant_id, 2);
            chk("t4_ready0_low", req_ready[0], 0);
        end
        want[2] = 1;
        repeat (12) step();
        want[0] = 0; want[2] = 0;
        max2 = 0; min0 = 32'hFFFF_FFFF; n0 = 0;
        foreach (wr_cyc[j]) begin
            if (wr_tag[j] == 2 && wr_cyc[j] > max2) max2 = wr_cyc[j];
            if (wr_tag[j] == 0) begin
                n0++;
                if (wr_cyc[j] < min0) min0 = wr_cyc[j];
            end
        end
        chk("t4_req0_after_req2", (n0 == 2) && (max2 < min0), 1);

        // Asynchronous reset during a burst from requester 3
        plen[3] = 4; budget[3] = 4; want[3] = 1;
        repeat (3) step();
        @(posedge clk_a);
        #1 rst_a = 1'b0;
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_wr_en", fifo_wr_en, 0);
        chk("t5_async_ready", req_ready, 0);
        chk("t5_async_grant", grant_id, 0);
        step();
        @(posedge clk_a);
        #1 rst_a = 1'b1;
        clear_trace();
        plen[0] = 2; budget[0] = 2; want[0] = 1;
        repeat (10) step();
        want[0] = 0; want[3] = 0;
        chk("t5_nwrites", wr_cyc.size(), 4);
        if (wr_tag.size() > 0) chk("t5_first_tag", wr_tag[0], 0);

        // Randomized traffic
        rand_mode = 1;
        for (int i = 0; i < N; i++) begin
            pos[i] = 0;
            plen[i] = $urandom_range(1, 8);
            budget[i] = 32'hFFFF_FFFF;
        end
        repeat (10000) begin
            for (int i = 0; i < N; i++) want[i] = ($urandom_range(0, 3) != 0);
            full_w = ($urandom_range(0, 4) == 0);
            step();
        end
        for (int i = 0; i < N; i++) want[i] = 0;
        full_w = 0;
        repeat (10) step();
        tot_acc = 0;
        tot_wr = 0;
        for (int i = 0; i < N; i++) begin
            tot_acc += seq[i];
            tot_wr  += sb_cnt[i];
        end
        chk("accepted_vs_written", tot_acc, tot_wr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
